// File: rtl/vector_merge_group_sequencer_pkg.sv
// Shared types for the vector merge group sequencer: FSM states, writeback tags,
// decoded op control and the LMUL-to-group-size decode.
package vector_merge_group_sequencer_pkg;

  localparam int NUM_VREGS       = 32;
  localparam int VRF_INDEX_WIDTH = $clog2(NUM_VREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } merge_sequencer_state_t;

  typedef struct packed {
    logic                       valid;
    logic [VRF_INDEX_WIDTH-1:0] index;
    logic                       last;
  } writeback_tag_t;

  // Decoded merge-op control, carried opaquely to the merge unit.
  typedef struct packed {
    logic [3:0] merge_op;
    logic       vm;
    logic [2:0] frm;
    logic [1:0] sew;
  } execution_vector_t;

  // Registers per LMUL group; fractional LMUL still occupies one register, 0 flags reserved.
  function automatic logic [3:0] vlmul_to_group_size(input logic [2:0] vlmul);
    logic [3:0] group_size;
    case (vlmul)
      3'b000:  group_size = 4'd1;
      3'b001:  group_size = 4'd2;
      3'b010:  group_size = 4'd4;
      3'b011:  group_size = 4'd8;
      3'b100:  group_size = 4'd0;
      default: group_size = 4'd1;
    endcase
    return group_size;
  endfunction

endpackage

// File: rtl/vector_writeback_tag_pipe.sv
// Shift register of writeback tags that tracks each issued slice until its
// merge result is ready to be written back.
module vector_writeback_tag_pipe
  import vector_merge_group_sequencer_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  writeback_tag_t push_tag,
  output logic           head_valid,
  output writeback_tag_t tail_tag
);

  writeback_tag_t stage_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg[gi] <= '0;
          end else begin
            stage_reg[gi] <= push_tag;
          end
        end
      end else begin : g_body
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg[gi] <= '0;
          end else begin
            stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign head_valid = stage_reg[0].valid;
  assign tail_tag   = stage_reg[DEPTH-1];

endmodule

// File: rtl/vector_merge_group_sequencer.sv
// Issue/writeback sequencer for the vector FP merge unit: walks an LMUL register
// group one slice per cycle and retires each result slice after the unit latency.
module vector_merge_group_sequencer
  import vector_merge_group_sequencer_pkg::*;
#(
  parameter int VLEN         = 128,
  parameter int UNIT_LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  execution_vector_t          execution_vector,
  input  logic [2:0]                 vlmul,
  input  logic [VRF_INDEX_WIDTH-1:0] vs2_index,
  input  logic [VRF_INDEX_WIDTH-1:0] vs1_index,
  input  logic [VRF_INDEX_WIDTH-1:0] vd_index,
  output logic                       vrf_read_enable,
  output logic [VRF_INDEX_WIDTH-1:0] vrf_read_index_a,
  output logic [VRF_INDEX_WIDTH-1:0] vrf_read_index_b,
  input  logic [VLEN-1:0]            vrf_read_data_a,
  input  logic [VLEN-1:0]            vrf_read_data_b,
  output execution_vector_t          unit_execution_vector,
  output logic [VLEN-1:0]            unit_vs2,
  output logic [VLEN-1:0]            unit_vs1,
  input  logic [VLEN-1:0]            unit_vd,
  output logic                       vrf_write_enable,
  output logic [VRF_INDEX_WIDTH-1:0] vrf_write_index,
  output logic [VLEN-1:0]            vrf_write_data,
  output logic                       done,
  output logic                       error
);

  localparam int TAG_DEPTH = 1 + UNIT_LATENCY;

  merge_sequencer_state_t     state_reg, state_next;
  logic [3:0]                 slice_reg, slice_next;
  logic [3:0]                 group_size_reg;
  logic [VRF_INDEX_WIDTH-1:0] vs2_base_reg, vs1_base_reg, vd_base_reg;
  execution_vector_t          execution_vector_reg;

  logic                       accept;
  logic [3:0]                 issue_group_size;
  logic [VRF_INDEX_WIDTH-1:0] issue_align_mask;
  logic                       issue_aligned;
  logic [VRF_INDEX_WIDTH-1:0] slice_offset;
  logic                       last_slice;
  writeback_tag_t             push_tag;
  writeback_tag_t             tail_tag;
  logic                       operand_valid;

  // Base indices must be group-aligned so base+g never leaves the register file.
  assign issue_group_size = vlmul_to_group_size(vlmul);
  assign issue_align_mask = VRF_INDEX_WIDTH'(issue_group_size - 4'd1);
  assign issue_aligned    = (issue_group_size != 4'd0)
                          && ((vs2_index & issue_align_mask) == '0)
                          && ((vs1_index & issue_align_mask) == '0)
                          && ((vd_index  & issue_align_mask) == '0);

  assign slice_offset = VRF_INDEX_WIDTH'(slice_reg);
  assign last_slice   = (slice_reg == group_size_reg - 4'd1);

  always_comb begin
    state_next       = state_reg;
    slice_next       = slice_reg;
    accept           = 1'b0;
    issue_ready      = 1'b0;
    vrf_read_enable  = 1'b0;
    vrf_read_index_a = '0;
    vrf_read_index_b = '0;
    push_tag         = '0;
    done             = 1'b0;
    error            = 1'b0;

    case (state_reg)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          accept     = 1'b1;
          slice_next = '0;
          state_next = issue_aligned ? READ : ERROR;
        end
      end
      READ: begin
        vrf_read_enable  = 1'b1;
        vrf_read_index_a = vs2_base_reg + slice_offset;
        vrf_read_index_b = vs1_base_reg + slice_offset;
        push_tag.valid   = 1'b1;
        push_tag.index   = vd_base_reg + slice_offset;
        push_tag.last    = last_slice;
        if (last_slice) begin
          slice_next = '0;
          state_next = DRAIN;
        end else begin
          slice_next = slice_reg + 4'd1;
        end
      end
      DRAIN: begin
        // Completion coincides with the final slice write.
        if (tail_tag.valid && tail_tag.last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      ERROR: begin
        done       = 1'b1;
        error      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg            <= IDLE;
      slice_reg            <= '0;
      group_size_reg       <= '0;
      vs2_base_reg         <= '0;
      vs1_base_reg         <= '0;
      vd_base_reg          <= '0;
      execution_vector_reg <= '0;
    end else begin
      state_reg <= state_next;
      slice_reg <= slice_next;
      if (accept) begin
        group_size_reg       <= issue_group_size;
        vs2_base_reg         <= vs2_index;
        vs1_base_reg         <= vs1_index;
        vd_base_reg          <= vd_index;
        execution_vector_reg <= execution_vector;
      end
    end
  end

  vector_writeback_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_tag   (push_tag),
    .head_valid (operand_valid),
    .tail_tag   (tail_tag)
  );

  assign unit_execution_vector = execution_vector_reg;
  assign unit_vs2              = operand_valid ? vrf_read_data_a : '0;
  assign unit_vs1              = operand_valid ? vrf_read_data_b : '0;

  assign vrf_write_enable = tail_tag.valid;
  assign vrf_write_index  = tail_tag.valid ? tail_tag.index : '0;
  assign vrf_write_data   = tail_tag.valid ? unit_vd : '0;

endmodule

// File: tb/tb_vector_merge_group_sequencer.sv
// Randomized self-checking bench: per-op expectations come from a cycle-indexed
// model of group size, alignment and the fixed issue/writeback timing.
module tb_vector_merge_group_sequencer;
  import vector_merge_group_sequencer_pkg::*;

  localparam int VLEN = 128;
  localparam int UL   = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              issue_valid;
  logic              issue_ready;
  execution_vector_t execution_vector;
  logic [2:0]        vlmul;
  logic [4:0]        vs2_index, vs1_index, vd_index;
  logic              vrf_read_enable;
  logic [4:0]        vrf_read_index_a, vrf_read_index_b;
  logic [VLEN-1:0]   vrf_read_data_a, vrf_read_data_b;
  execution_vector_t unit_execution_vector;
  logic [VLEN-1:0]   unit_vs2, unit_vs1, unit_vd;
  logic              vrf_write_enable;
  logic [4:0]        vrf_write_index;
  logic [VLEN-1:0]   vrf_write_data;
  logic              done, error;

  logic [VLEN-1:0]   vrf_mem [32];
  int                assertions_evaluated = 0;
  int                failures = 0;

  always #5 clock = ~clock;

  vector_merge_group_sequencer #(.VLEN(VLEN), .UNIT_LATENCY(UL)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .execution_vector      (execution_vector),
    .vlmul                 (vlmul),
    .vs2_index             (vs2_index),
    .vs1_index             (vs1_index),
    .vd_index              (vd_index),
    .vrf_read_enable       (vrf_read_enable),
    .vrf_read_index_a      (vrf_read_index_a),
    .vrf_read_index_b      (vrf_read_index_b),
    .vrf_read_data_a       (vrf_read_data_a),
    .vrf_read_data_b       (vrf_read_data_b),
    .unit_execution_vector (unit_execution_vector),
    .unit_vs2              (unit_vs2),
    .unit_vs1              (unit_vs1),
    .unit_vd               (unit_vd),
    .vrf_write_enable      (vrf_write_enable),
    .vrf_write_index       (vrf_write_index),
    .vrf_write_data        (vrf_write_data),
    .done                  (done),
    .error                 (error)
  );

  // Register file with one-cycle synchronous read.
  always @(posedge clock) begin
    if (vrf_read_enable) begin
      vrf_read_data_a <= vrf_mem[vrf_read_index_a];
      vrf_read_data_b <= vrf_mem[vrf_read_index_b];
    end
  end

  task automatic check_value(input string tag, input logic [VLEN-1:0] observed,
                             input logic [VLEN-1:0] expected);
    assertions_evaluated++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [VLEN-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic execution_vector_t rand_ev();
    logic [31:0] r;
    r = $urandom();
    return execution_vector_t'(r[$bits(execution_vector_t)-1:0]);
  endfunction

  // Registers in the group: 2**vlmul for integer LMUL, 1 for fractional, 0 when reserved.
  function automatic int model_group(input logic [2:0] vl);
    if (vl < 3'd4) return 1 << vl;
    if (vl == 3'd4) return 0;
    return 1;
  endfunction

  function automatic bit model_err(input logic [2:0] vl, input logic [4:0] a, b, d);
    int g;
    g = model_group(vl);
    if (g == 0) return 1'b1;
    return (int'(a) % g != 0) || (int'(b) % g != 0) || (int'(d) % g != 0);
  endfunction

  // Issue one op at the current cycle (cycle 0) and check cycles 1..done+1.
  task automatic run_op(input logic [2:0] vl, input logic [4:0] a, b, d,
                        input execution_vector_t ev, input bit hold,
                        input logic [2:0] nvl, input logic [4:0] na, nb, nd,
                        input execution_vector_t nev);
    int g, last_c, writes;
    bit err, exp_rd, exp_wr;
    g      = model_group(vl);
    err    = model_err(vl, a, b, d);
    last_c = err ? 1 : g + 1 + UL;
    writes = 0;
    vlmul = vl; vs2_index = a; vs1_index = b; vd_index = d;
    execution_vector = ev; issue_valid = 1'b1;
    #1 check_value("issue_ready_idle", issue_ready, 1'b1);
    @(posedge clock);
    for (int c = 1; c <= last_c + 1; c++) begin
      @(negedge clock);
      if (c == 1) begin
        if (hold) begin
          vlmul = nvl; vs2_index = na; vs1_index = nb; vd_index = nd; execution_vector = nev;
        end else begin
          issue_valid = 1'b0;
        end
      end
      unit_vd = rand_word();
      #1;
      if (c == last_c + 1) begin
        check_value("ready_after_done", issue_ready, 1'b1);
        check_value("done_cleared", done, 1'b0);
      end else begin
        exp_rd = !err && c <= g;
        exp_wr = !err && c >= 2 + UL && c <= g + 1 + UL;
        check_value("ready_busy", issue_ready, 1'b0);
        check_value("unit_ev_held", unit_execution_vector, ev);
        check_value("read_enable", vrf_read_enable, exp_rd);
        if (exp_rd) begin
          check_value("read_index_a", vrf_read_index_a, a + 5'(c - 1));
          check_value("read_index_b", vrf_read_index_b, b + 5'(c - 1));
        end
        if (!err && c >= 2 && c <= g + 1) begin
          check_value("unit_vs2", unit_vs2, vrf_mem[int'(a) + c - 2]);
          check_value("unit_vs1", unit_vs1, vrf_mem[int'(b) + c - 2]);
        end
        check_value("write_enable", vrf_write_enable, exp_wr);
        if (exp_wr) begin
          writes++;
          check_value("write_index", vrf_write_index, d + 5'(c - 2 - UL));
          check_value("write_data", vrf_write_data, unit_vd);
        end
        check_value("done", done, c == last_c);
        check_value("error", error, err && c == last_c);
      end
    end
    $display("op vlmul=%b vs2=%0d vs1=%0d vd=%0d group=%0d err=%0b writes=%0d hold=%0b",
             vl, a, b, d, g, err, writes, hold);
  endtask

  task automatic run_single(input logic [2:0] vl, input logic [4:0] a, b, d);
    run_op(vl, a, b, d, rand_ev(), 1'b0, 3'b0, 5'd0, 5'd0, 5'd0, execution_vector_t'('0));
  endtask

  logic [2:0]        op_vl [41];
  logic [4:0]        op_a [41], op_b [41], op_d [41];
  execution_vector_t op_ev [41];

  initial begin
    execution_vector_t ev1, ev2;
    int g;
    reset_n = 1'b0; issue_valid = 1'b0; execution_vector = '0; vlmul = '0;
    vs2_index = '0; vs1_index = '0; vd_index = '0; unit_vd = '0;
    vrf_read_data_a = '0; vrf_read_data_b = '0;
    for (int i = 0; i < 32; i++) vrf_mem[i] = rand_word();

    repeat (2) @(negedge clock);
    check_value("reset_ready", issue_ready, 1'b1);
    check_value("reset_read_en", vrf_read_enable, 1'b0);
    check_value("reset_write_en", vrf_write_enable, 1'b0);
    check_value("reset_done", done, 1'b0);
    check_value("reset_error", error, 1'b0);
    check_value("reset_unit_ev", unit_execution_vector, '0);
    reset_n = 1'b1;

    run_single(3'b000, 5'd4, 5'd8, 5'd12);
    run_single(3'b010, 5'd8, 5'd16, 5'd24);
    run_single(3'b011, 5'd8, 5'd16, 5'd4);
    run_single(3'b100, 5'd0, 5'd0, 5'd0);
    run_single(3'b110, 5'd1, 5'd2, 5'd3);

    // issue_valid stays high through the first op with different fields on the bus.
    ev1 = rand_ev();
    ev2 = ~ev1;
    run_op(3'b001, 5'd2, 5'd4, 5'd6, ev1, 1'b1, 3'b000, 5'd9, 5'd10, 5'd11, ev2);
    run_op(3'b000, 5'd9, 5'd10, 5'd11, ev2, 1'b0, 3'b0, 5'd0, 5'd0, 5'd0, ev1);

    // Reset in the middle of an LMUL=8 op drops every pending write.
    vlmul = 3'b011; vs2_index = 5'd8; vs1_index = 5'd16; vd_index = 5'd24;
    execution_vector = rand_ev(); issue_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      issue_valid = 1'b0;
      #1 check_value("abort_read_index", vrf_read_index_a, 5'(7 + c));
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_value("abort_ready", issue_ready, 1'b1);
    check_value("abort_read_en", vrf_read_enable, 1'b0);
    check_value("abort_write_en", vrf_write_enable, 1'b0);
    check_value("abort_done", done, 1'b0);
    check_value("abort_unit_ev", unit_execution_vector, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #1;
      check_value("post_abort_write_en", vrf_write_enable, 1'b0);
      check_value("post_abort_ready", issue_ready, 1'b1);
    end

    for (int i = 0; i < 41; i++) begin
      op_vl[i] = 3'($urandom_range(0, 7));
      g = model_group(op_vl[i]);
      if (g != 0 && $urandom_range(0, 3) != 0) begin
        op_a[i] = 5'(($urandom_range(0, 31) / g) * g);
        op_b[i] = 5'(($urandom_range(0, 31) / g) * g);
        op_d[i] = 5'(($urandom_range(0, 31) / g) * g);
      end else begin
        op_a[i] = 5'($urandom_range(0, 31));
        op_b[i] = 5'($urandom_range(0, 31));
        op_d[i] = 5'($urandom_range(0, 31));
      end
      op_ev[i] = rand_ev();
    end
    for (int i = 0; i < 40; i++) begin
      run_op(op_vl[i], op_a[i], op_b[i], op_d[i], op_ev[i], (i < 39) && $urandom_range(0, 1) == 1,
             op_vl[i+1], op_a[i+1], op_b[i+1], op_d[i+1], op_ev[i+1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
